hp_filter_signed: RTL and testbench

Cascaded shift-coefficient first-order high-pass filter for signed samples: the complement of `lp_filter_signed`. Each stage subtracts its own running exponential average from its input, which removes DC and slow drift. Output is the fast component, with a registered "settled" flag. It sits next to the low-pass filter in the sensor datapath and receives the same CE-qualified sample stream.

---
 rtl/hp_filter_signed.sv | 122 ++++++++++++
 tb/tb_hp_filter_signed.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/hp_filter_signed.sv
// Cascaded shift-coefficient high-pass filter for signed samples with a registered settled flag.
// Define HP_FILTER_SATURATE_EN to clamp instead of wrap when the output is narrower than the internal width.
module hp_filter_signed #(
    parameter int          IN_DATA_BITS     = 32,
    parameter int          OUT_DATA_BITS    = 32,
    parameter int          SHIFT_BITS       = 5,
    parameter int          STAGE_COUNT      = 2,
    parameter int unsigned SETTLE_THRESHOLD = 16,
    parameter int          SETTLE_CYCLES    = 64
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            CE,
    input  logic signed [IN_DATA_BITS-1:0]  IN_VALUE,
    output logic signed [OUT_DATA_BITS-1:0] OUT_VALUE,
    output logic                            SETTLED
);

    localparam int IW = IN_DATA_BITS + STAGE_COUNT;
    localparam int AW = IW + SHIFT_BITS;
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES);
    localparam longint THR = longint'(SETTLE_THRESHOLD);

    logic signed [IW-1:0]            x0;
    logic signed [IW-1:0]            y_last;
    logic signed [OUT_DATA_BITS-1:0] fitted;
    logic signed [63:0]              fitted_wide;
    logic                            most_neg;
    logic                            in_limit;
    logic [CW-1:0]                   cnt;
    logic [CW-1:0]                   cnt_next;

    assign x0 = IW'(IN_VALUE);

    generate
        if (STAGE_COUNT == 0) begin : g_bypass
            assign y_last = x0;
        end else begin : g_chain
            logic signed [IW-1:0] stage_y [STAGE_COUNT];

            for (genvar k = 0; k < STAGE_COUNT; k++) begin : g_stage
                logic signed [IW-1:0] x_in;
                logic signed [AW-1:0] acc;
                logic signed [AW-1:0] diff_wide;
                logic signed [IW-1:0] y_reg;

                if (k == 0) begin : g_first
                    assign x_in = x0;
                end else begin : g_next
                    assign x_in = stage_y[k-1];
                end

                // acc tracks 2^SHIFT_BITS times the running average; the difference always fits in IW
                assign diff_wide = AW'(x_in) - (acc >>> SHIFT_BITS);

                always_ff @(posedge CLK or negedge RESET) begin
                    if (!RESET) begin
                        acc   <= '0;
                        y_reg <= '0;
                    end else if (CE) begin
                        acc   <= acc + diff_wide;
                        y_reg <= diff_wide[IW-1:0];
                    end
                end

                assign stage_y[k] = y_reg;
            end

            assign y_last = stage_y[STAGE_COUNT-1];
        end
    endgenerate

    generate
        if (OUT_DATA_BITS >= IW) begin : g_extend
            assign fitted = OUT_DATA_BITS'(y_last);
        end else begin : g_narrow
`ifdef HP_FILTER_SATURATE_EN
            logic [IW-OUT_DATA_BITS:0] upper;
            assign upper = y_last[IW-1:OUT_DATA_BITS-1];

            // Bits above the output sign bit must all agree, otherwise clamp toward the input sign
            always_comb begin
                fitted = y_last[OUT_DATA_BITS-1:0];
                if (!((&upper) || (~|upper))) begin
                    fitted = y_last[IW-1] ? {1'b1, {(OUT_DATA_BITS-1){1'b0}}}
                                          : {1'b0, {(OUT_DATA_BITS-1){1'b1}}};
                end
            end
`else
            logic unused_upper_bits;
            assign unused_upper_bits = ^y_last[IW-1:OUT_DATA_BITS];
            assign fitted = y_last[OUT_DATA_BITS-1:0];
`endif
        end
    endgenerate

    // The most negative code has no representable magnitude, so it never counts as in-limit
    assign fitted_wide = 64'(fitted);
    assign most_neg    = fitted[OUT_DATA_BITS-1] & ~|fitted[OUT_DATA_BITS-2:0];
    assign in_limit    = (fitted_wide <= THR) && (fitted_wide >= -THR) && !most_neg;

    always_comb begin
        cnt_next = '0;
        if (in_limit) begin
            cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            OUT_VALUE <= '0;
            cnt       <= '0;
            SETTLED   <= 1'b0;
        end else if (CE) begin
            OUT_VALUE <= fitted;
            cnt       <= cnt_next;
            SETTLED   <= (cnt_next == CNT_MAX);
        end
    end

endmodule

// File: tb/tb_hp_filter_signed.sv
// Bench for hp_filter_signed: four configurations driven together and compared every cycle
// against an arithmetic reference model, plus directed step, saturation, gating and reset cases.
module tb_hp_filter_signed;

    logic clock  = 1'b0;
    logic resetN = 1'b1;
    logic ce     = 1'b0;
    logic signed [31:0] in32 = '0;
    logic signed [15:0] in16 = '0;

    logic signed [31:0] outA, outB;
    logic signed [15:0] outC, outD;
    logic setA, setB, setC, setD;

    int errorCount = 0;
    int checkCount = 0;

`ifdef HP_FILTER_SATURATE_EN
    localparam longint SAT_EXPECT = -32768;
`else
    localparam longint SAT_EXPECT = 1;
`endif

    // Per-instance configuration mirrored for the reference model: A, B, C, D
    int cfgStages  [4] = '{2, 1, 1, 0};
    int cfgShift   [4] = '{5, 5, 5, 5};
    int cfgInBits  [4] = '{32, 32, 16, 16};
    int cfgOutBits [4] = '{32, 32, 16, 16};
    int cfgThr     [4] = '{16, 16, 16, 16};
    int cfgCycles  [4] = '{64, 64, 4, 3};

    longint mS   [4][8];
    longint mY   [4][8];
    longint mOut [4];
    int     mRun [4];
    bit     mSet [4];

    hp_filter_signed #(.IN_DATA_BITS(32), .OUT_DATA_BITS(32), .SHIFT_BITS(5), .STAGE_COUNT(2),
                       .SETTLE_THRESHOLD(16), .SETTLE_CYCLES(64)) dutA (
        .CLK(clock), .RESET(resetN), .CE(ce), .IN_VALUE(in32), .OUT_VALUE(outA), .SETTLED(setA));

    hp_filter_signed #(.IN_DATA_BITS(32), .OUT_DATA_BITS(32), .SHIFT_BITS(5), .STAGE_COUNT(1),
                       .SETTLE_THRESHOLD(16), .SETTLE_CYCLES(64)) dutB (
        .CLK(clock), .RESET(resetN), .CE(ce), .IN_VALUE(in32), .OUT_VALUE(outB), .SETTLED(setB));

    hp_filter_signed #(.IN_DATA_BITS(16), .OUT_DATA_BITS(16), .SHIFT_BITS(5), .STAGE_COUNT(1),
                       .SETTLE_THRESHOLD(16), .SETTLE_CYCLES(4)) dutC (
        .CLK(clock), .RESET(resetN), .CE(ce), .IN_VALUE(in16), .OUT_VALUE(outC), .SETTLED(setC));

    hp_filter_signed #(.IN_DATA_BITS(16), .OUT_DATA_BITS(16), .SHIFT_BITS(5), .STAGE_COUNT(0),
                       .SETTLE_THRESHOLD(16), .SETTLE_CYCLES(3)) dutD (
        .CLK(clock), .RESET(resetN), .CE(ce), .IN_VALUE(in16), .OUT_VALUE(outD), .SETTLED(setD));

    always #5 clock = ~clock;

    // Floor division by a power of two written as plain integer arithmetic
    function automatic longint floorDiv(longint s, int sh);
        longint p;
        p = longint'(1) << sh;
        if (s >= 0) return s / p;
        return -((-s + p - 1) / p);
    endfunction

    function automatic longint fitValue(longint v, int iw, int ob);
        longint half;
        half = longint'(1) << (ob - 1);
        if (ob >= iw) return v;
`ifdef HP_FILTER_SATURATE_EN
        if (v > half - 1) return half - 1;
        if (v < -half) return -half;
        return v;
`else
        begin
            longint r;
            r = (v + half) % (2 * half);
            if (r < 0) r = r + 2 * half;
            return r - half;
        end
`endif
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 8; k++) begin
                mS[i][k] = 0;
                mY[i][k] = 0;
            end
            mOut[i] = 0;
            mRun[i] = 0;
            mSet[i] = 1'b0;
        end
    endtask

    // One sample through instance i: all stages use the previous sample's state
    task automatic modelStep(int i, longint inVal);
        longint nd [8];
        longint x, yLast, half, mag;
        int st, iw;
        st = cfgStages[i];
        iw = cfgInBits[i] + st;
        if (st == 0) yLast = inVal;
        else yLast = mY[i][st-1];
        for (int k = 0; k < st; k++) begin
            if (k == 0) x = inVal;
            else x = mY[i][k-1];
            nd[k] = x - floorDiv(mS[i][k], cfgShift[i]);
        end
        mOut[i] = fitValue(yLast, iw, cfgOutBits[i]);
        for (int k = 0; k < st; k++) begin
            mS[i][k] = mS[i][k] + nd[k];
            mY[i][k] = nd[k];
        end
        half = longint'(1) << (cfgOutBits[i] - 1);
        mag  = (mOut[i] < 0) ? -mOut[i] : mOut[i];
        if (mag <= longint'(cfgThr[i]) && mOut[i] != -half) mRun[i] = mRun[i] + 1;
        else mRun[i] = 0;
        mSet[i] = (mRun[i] >= cfgCycles[i]);
    endtask

    task automatic checkOutput(string tag, logic signed [63:0] got, logic signed [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic compareModels();
        checkOutput("A.out", 64'(outA), mOut[0]);
        checkOutput("A.settled", 64'(setA), 64'(mSet[0]));
        checkOutput("B.out", 64'(outB), mOut[1]);
        checkOutput("B.settled", 64'(setB), 64'(mSet[1]));
        checkOutput("C.out", 64'(outC), mOut[2]);
        checkOutput("C.settled", 64'(setC), 64'(mSet[2]));
        checkOutput("D.out", 64'(outD), mOut[3]);
        checkOutput("D.settled", 64'(setD), 64'(mSet[3]));
    endtask

    // Drive one cycle of inputs, advance the model on a real CE edge, compare at the falling edge
    task automatic applyStimulus(bit ceVal, logic signed [31:0] v32, logic signed [15:0] v16);
        ce   = ceVal;
        in32 = v32;
        in16 = v16;
        @(posedge clock);
        if (resetN && ceVal) begin
            modelStep(0, v32);
            modelStep(1, v32);
            modelStep(2, v16);
            modelStep(3, v16);
        end
        @(negedge clock);
        compareModels();
    endtask

    initial begin
        int noise;
        modelReset();
        #1 resetN = 1'b0;
        #2 compareModels();
        applyStimulus(1'b1, 32'sd12345, 16'sd77);
        applyStimulus(1'b1, -32'sd999, -16'sd5);
        resetN = 1'b1;

        // DC step from the first edge after reset
        for (int n = 1; n <= 2000; n++) begin
            applyStimulus(1'b1, 32'sd109377165, 16'sd32767);
            if (n == 2) checkOutput("B.firstOut", 64'(outB), 64'sd109377165);
            if (n == 3) checkOutput("B.secondOut", 64'(outB), 64'sd105959129);
        end
        checkOutput("B.dcZero", 64'(outB), 64'sd0);
        checkOutput("B.dcSettled", 64'(setB), 64'sd1);
        checkOutput("C.dcZero", 64'(outC), 64'sd0);

        // Large negative step; saturation/wrap on the narrow instance
        applyStimulus(1'b1, -32'sd218754328, -16'sd32768);
        checkOutput("B.stepHold", 64'(setB), 64'sd1);
        applyStimulus(1'b1, -32'sd218754328, -16'sd32768);
        checkOutput("B.stepOut", 64'(outB), -64'sd328131493);
        checkOutput("B.stepSettled", 64'(setB), 64'sd0);
        checkOutput("C.satOut", 64'(outC), SAT_EXPECT);
        for (int n = 0; n < 300; n++) applyStimulus(1'b1, -32'sd218754328, -16'sd32768);

        // Full-range random samples with random CE
        for (int n = 0; n < 600; n++) begin
            applyStimulus($urandom_range(0, 9) != 0, $urandom, 16'($urandom));
        end

        // Small-amplitude noise around a DC level so the settled detectors engage
        for (int n = 0; n < 400; n++) begin
            noise = int'($urandom_range(0, 6)) - 3;
            applyStimulus($urandom_range(0, 7) != 0, 32'(5000 + noise), 16'(noise));
        end

        // Long CE gap in the middle of a decay
        for (int n = 0; n < 20; n++) applyStimulus(1'b1, -32'sd70000, 16'sd9000);
        for (int n = 0; n < 100; n++) applyStimulus(1'b0, $urandom, 16'($urandom));
        for (int n = 0; n < 40; n++) applyStimulus(1'b1, -32'sd70000, 16'sd9000);

        // Asynchronous reset between edges, held across one edge with CE high
        #2 resetN = 1'b0;
        #1;
        checkOutput("A.rstOut", 64'(outA), 64'sd0);
        checkOutput("A.rstSettled", 64'(setA), 64'sd0);
        checkOutput("B.rstOut", 64'(outB), 64'sd0);
        checkOutput("C.rstOut", 64'(outC), 64'sd0);
        checkOutput("D.rstOut", 64'(outD), 64'sd0);
        modelReset();
        applyStimulus(1'b1, 32'sd4321, 16'sd1234);
        resetN = 1'b1;

        applyStimulus(1'b1, 32'sd1000, -16'sd5);
        checkOutput("D.passThrough", 64'(outD), -64'sd5);
        checkOutput("A.lat1", 64'(outA), 64'sd0);
        applyStimulus(1'b1, 32'sd1000, -16'sd5);
        checkOutput("A.lat2", 64'(outA), 64'sd0);
        applyStimulus(1'b1, 32'sd1000, -16'sd5);
        checkOutput("A.firstOut", 64'(outA), 64'sd1000);
        for (int n = 0; n < 10; n++) applyStimulus(1'b1, 32'sd1000, -16'sd5);
        checkOutput("D.noDecay", 64'(outD), -64'sd5);
        checkOutput("D.settled", 64'(setD), 64'sd1);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
